// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment frame decoder:
//   - SEG_* active-low segment patterns, bit order {a,b,c,d,e,f,g}
//   - CODE_BLANK / CODE_BAD nibble codes
//   - output-side state encoding
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b1100000;  // 6 without the top bar
  localparam logic [6:0] SEG_6_ALT = 7'b0100000;  // 6 with the top bar
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;  // 9 without the bottom bar
  localparam logic [6:0] SEG_9_ALT = 7'b0000100;  // 9 with the bottom bar
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational decode of one active-low 7-segment pattern to BCD.
//   Ports:
//     seg_i  [6:0]  segments, active-low, {a,b,c,d,e,f,g}
//     bcd_o  [3:0]  decoded digit (CODE_BAD when unrecognised)
//     err_o         pattern not recognised
//   Macro SEG_BLANK_EN: when defined, the all-off pattern is a legal blank
//   digit (CODE_BLANK, no error); otherwise it is treated as unrecognised.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  always_comb begin
    bcd_o = CODE_BAD;
    err_o = 1'b0;
    case (seg_i)
      SEG_0:            bcd_o = 4'd0;
      SEG_1:            bcd_o = 4'd1;
      SEG_2:            bcd_o = 4'd2;
      SEG_3:            bcd_o = 4'd3;
      SEG_4:            bcd_o = 4'd4;
      SEG_5:            bcd_o = 4'd5;
      SEG_6, SEG_6_ALT: bcd_o = 4'd6;
      SEG_7:            bcd_o = 4'd7;
      SEG_8:            bcd_o = 4'd8;
      SEG_9, SEG_9_ALT: bcd_o = 4'd9;
`ifdef SEG_BLANK_EN
      SEG_BLANK:        bcd_o = CODE_BLANK;
`endif
      default: begin
        bcd_o = CODE_BAD;
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder
//   Snoops a multiplexed 7-segment display bus, decodes each stable digit
//   back to BCD, assembles a NUM_DIGITS-wide frame and offers it over a
//   valid/ready handshake.
//   Ports:
//     clk          system clock, rising edge
//     reset        synchronous active-high reset
//     an           digit strobes, active-low (one low = legal)
//     seg          segments, active-low, {a,b,c,d,e,f,g}
//     frame_bcd    digit i at [4i+3:4i]
//     frame_err    bit i = digit i held an unrecognised pattern
//     frame_valid  frame_bcd/frame_err valid, held until accepted
//     frame_ready  consumer accept
//     overrun      sticky: a completed frame was dropped
//   Macro SEG_BLANK_EN selects blank-digit decoding (see seg7_pattern_decode).
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0]   prev_an_q;
  logic [6:0]              prev_seg_q;
  logic [RW-1:0]           run_q, run_d;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic [NUM_DIGITS-1:0][3:0] shadow_bcd_q;
  logic [NUM_DIGITS-1:0]   shadow_err_q;
  logic [4*NUM_DIGITS-1:0] frame_bcd_q, offer_bcd;
  logic [NUM_DIGITS-1:0]   frame_err_q, offer_err;
  logic                    overrun_q;
  out_state_e              state_q, state_d;

  logic [NUM_DIGITS-1:0] sel;
  logic                  onehot, same, capture, complete, load;
  logic [3:0]            dec_bcd;
  logic                  dec_err;

  seg7_pattern_decode u_decode (
    .seg_i (seg),
    .bcd_o (dec_bcd),
    .err_o (dec_err)
  );

  assign sel    = ~an;
  assign onehot = $onehot(sel);
  assign same   = (an == prev_an_q) && (seg == prev_seg_q);

  // Run length of the current (an,seg) pair. Capture fires on the cycle
  // the run first reaches RUN_MAX; a saturated run (same && run_q==MAX)
  // is the same dwell and must not capture again.
  always_comb begin
    run_d   = '0;
    capture = 1'b0;
    if (onehot) begin
      if (same) begin
        run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
      end else begin
        run_d = RW'(1);
      end
      capture = (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));
    end
  end

  assign complete = capture && (&(seen_q | sel));

  // Frame offered on completion includes the digit captured this cycle.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign offer_bcd[4*gi +: 4] = (capture && sel[gi]) ? dec_bcd : shadow_bcd_q[gi];
    assign offer_err[gi]        = (capture && sel[gi]) ? dec_err : shadow_err_q[gi];

    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_bcd_q[gi] <= 4'h0;
        shadow_err_q[gi] <= 1'b0;
      end else if (capture && sel[gi]) begin
        shadow_bcd_q[gi] <= dec_bcd;
        shadow_err_q[gi] <= dec_err;
      end
    end
  end

  // Output side: a completed frame loads if the register is empty or is
  // being emptied by an accept in the same cycle; otherwise it is dropped.
  always_comb begin
    state_d = state_q;
    load    = complete && ((state_q == OUT_EMPTY) || frame_ready);
    case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL:  if (!load && frame_ready) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_an_q   <= '0;
      prev_seg_q  <= '0;
      run_q       <= '0;
      seen_q      <= '0;
      frame_bcd_q <= '0;
      frame_err_q <= '0;
      overrun_q   <= 1'b0;
      state_q     <= OUT_EMPTY;
    end else begin
      prev_an_q  <= an;
      prev_seg_q <= seg;
      run_q      <= run_d;
      state_q    <= state_d;
      if (complete) begin
        seen_q <= '0;
      end else if (capture) begin
        seen_q <= seen_q | sel;
      end
      if (load) begin
        frame_bcd_q <= offer_bcd;
        frame_err_q <= offer_err;
      end else if (complete) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign frame_bcd   = frame_bcd_q;
  assign frame_err   = frame_err_q;
  assign frame_valid = (state_q == OUT_FULL);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb_seg7_frame_decoder
//   Directed bench for seg7_frame_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. A small monitor records every handshake (valid && ready).
module tb_seg7_frame_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  int          acc_cnt = 0;
  logic [15:0] acc_bcd = '0;
  logic [3:0]  acc_err = '0;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                         P6 = 7'b1100000, P6A = 7'b0100000, P7 = 7'b0001111,
                         P8 = 7'b0000000, P9 = 7'b0001100, P9A = 7'b0000100,
                         PBLANK = 7'b1111111, PBAD = 7'b1111110;

  always #5 clk = ~clk;

  seg7_frame_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .frame_bcd   (frame_bcd),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  always @(posedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_bcd <= frame_bcd;
      acc_err <= frame_err;
      $display("handshake: bcd=%h err=%b", frame_bcd, frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show_digit(input int d, input logic [6:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      an  = ~(4'b0001 << d);
      seg = p;
    end
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3, input int n);
    show_digit(0, p0, n);
    show_digit(1, p1, n);
    show_digit(2, p2, n);
    show_digit(3, p3, n);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      an  = 4'hF;
      seg = 7'h7F;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    reset       = 1'b1;
    an          = 4'hF;
    seg         = 7'h7F;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_bcd", 32'(frame_bcd), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // Basic scan 1,2,3,4, ready=1
    frame_ready = 1'b1;
    scan4(P1, P2, P3, P4, 6);
    idle(3);
    check("scan_cnt", 32'(acc_cnt), 32'd1);
    check("scan_bcd", 32'(acc_bcd), 32'h4321);
    check("scan_err", 32'(acc_err), 32'h0);
    check("scan_valid_drop", 32'(frame_valid), 32'h0);
    check("scan_hold_bcd", 32'(frame_bcd), 32'h4321);

    // Dwell of 3 cycles is one short: nothing captured
    scan4(P5, P6, P7, P8, 3);
    scan4(P5, P6, P7, P8, 3);
    idle(3);
    check("short_cnt", 32'(acc_cnt), 32'd1);
    check("short_valid", 32'(frame_valid), 32'h0);

    // Two strobes low: ignored; then scan in order 2,3,0,1
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      an  = 4'b1100;
      seg = P8;
    end
    show_digit(2, P7, 6);
    show_digit(3, P9, 6);
    show_digit(0, P5, 6);
    show_digit(1, P6, 6);
    idle(3);
    check("multi_cnt", 32'(acc_cnt), 32'd2);
    check("multi_bcd", 32'(acc_bcd), 32'h9765);
    check("multi_err", 32'(acc_err), 32'h0);

    // Unrecognised pattern on digit 2, alternate 9 on digit 0
    scan4(P9A, P0, PBAD, P3, 6);
    idle(3);
    check("bad_cnt", 32'(acc_cnt), 32'd3);
    check("bad_bcd", 32'(acc_bcd), 32'h3F09);
    check("bad_err", 32'(acc_err), 32'h4);

    // Blank on digit 3, alternate 6 on digit 1
    scan4(P0, P6A, P2, PBLANK, 6);
    idle(3);
    check("blank_cnt", 32'(acc_cnt), 32'd4);
`ifdef SEG_BLANK_EN
    check("blank_bcd", 32'(acc_bcd), 32'hA260);
    check("blank_err", 32'(acc_err), 32'h0);
`else
    check("blank_bcd", 32'(acc_bcd), 32'hF260);
    check("blank_err", 32'(acc_err), 32'h8);
`endif

    // Back-pressure: two frames while ready=0
    frame_ready = 1'b0;
    scan4(P1, P2, P3, P4, 6);
    scan4(P5, P6, P7, P8, 6);
    idle(3);
    check("bp_cnt", 32'(acc_cnt), 32'd4);
    check("bp_valid", 32'(frame_valid), 32'h1);
    check("bp_bcd", 32'(frame_bcd), 32'h4321);
    check("bp_overrun", 32'(overrun), 32'h1);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("bp_acc_cnt", 32'(acc_cnt), 32'd5);
    check("bp_acc_bcd", 32'(acc_bcd), 32'h4321);
    check("bp_empty", 32'(frame_valid), 32'h0);
    frame_ready = 1'b1;
    scan4(P9, P8, P7, P6, 6);
    idle(3);
    check("bp_next_cnt", 32'(acc_cnt), 32'd6);
    check("bp_next_bcd", 32'(acc_bcd), 32'h6789);
    check("bp_overrun_sticky", 32'(overrun), 32'h1);

    // Reset clears overrun
    do_reset();
    check("rst2_overrun", 32'(overrun), 32'h0);
    check("rst2_bcd", 32'(frame_bcd), 32'h0);

    // Frame completes on the same cycle as an accept
    frame_ready = 1'b0;
    scan4(P0, P0, P0, P1, 6);
    idle(2);
    check("same_held", 32'(frame_bcd), 32'h1000);
    base = acc_cnt;
    show_digit(0, P2, 6);
    show_digit(1, P2, 6);
    show_digit(2, P2, 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      an          = 4'b0111;
      seg         = P5;
      frame_ready = (k == 3);
    end
    frame_ready = 1'b0;
    idle(2);
    check("same_acc_cnt", 32'(acc_cnt - base), 32'd1);
    check("same_acc_bcd", 32'(acc_bcd), 32'h1000);
    check("same_valid", 32'(frame_valid), 32'h1);
    check("same_bcd", 32'(frame_bcd), 32'h5222);
    check("same_overrun", 32'(overrun), 32'h0);

    // Reset after two captured digits discards the partial frame
    show_digit(0, P7, 6);
    show_digit(1, P7, 6);
    do_reset();
    check("mid_bcd", 32'(frame_bcd), 32'h0);
    check("mid_valid", 32'(frame_valid), 32'h0);
    check("mid_err", 32'(frame_err), 32'h0);
    show_digit(2, P3, 6);
    show_digit(3, P4, 6);
    idle(3);
    check("mid_partial_valid", 32'(frame_valid), 32'h0);
    show_digit(0, P1, 6);
    show_digit(1, P2, 6);
    idle(2);
    check("mid_full_valid", 32'(frame_valid), 32'h1);
    check("mid_full_bcd", 32'(frame_bcd), 32'h4321);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
